// File: rtl/fetch_ctrl_if.sv
// Instruction-memory request/acknowledge bundle between the fetch sequencer
// and the instruction memory.
interface fetch_ctrl_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;

  modport master (output imem_req, output imem_addr, input imem_ack, input imem_rdata);
  modport slave  (input imem_req, input imem_addr, output imem_ack, output imem_rdata);
endinterface

// File: rtl/fetch_ctrl.sv
// Fetch-stage sequencer: owns PC_F, runs the imem req/ack handshake, holds the
// IF/ID register and parks one fetched word while the hazard unit stalls.
module fetch_ctrl #(
  parameter logic [31:0] RESET_PC  = 32'h0000_3000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               stall,
  input  logic               br_taken_D,
  input  logic [31:0]        npc_in,
  fetch_ctrl_if.master       imem,
  output logic [31:0]        PC_F,
  output logic [31:0]        IR_D,
  output logic [31:0]        PC4_D,
  output logic               valid_D
);

  typedef enum logic {S_REQ, S_HOLD} state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] ir_q, ir_d;
  logic [31:0] pc4_q, pc4_d;
  logic        vld_q, vld_d;
  logic [31:0] buf_q, buf_d;
  logic        req;
  logic        advance;
  logic [31:0] instr;
  logic [31:0] pc_plus4;

  assign pc_plus4 = pc_q + 32'd4;

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ir_d    = ir_q;
    pc4_d   = pc4_q;
    vld_d   = vld_q;
    buf_d   = buf_q;
    req     = 1'b0;
    advance = 1'b0;
    instr   = imem.imem_rdata;

    case (state_q)
      S_REQ: begin
        req = 1'b1;
        if (imem.imem_ack) begin
          if (!stall) begin
            advance = 1'b1;
          end else begin
            // Stalled on arrival: park the word; the redirect decision waits for the advance.
            buf_d   = imem.imem_rdata;
            state_d = S_HOLD;
          end
        end
      end
      S_HOLD: begin
        if (!stall) begin
          advance = 1'b1;
          instr   = buf_q;
          state_d = S_REQ;
        end
      end
      default: state_d = S_REQ;
    endcase

    // IR_D only changes here, so a branch in D redirects exactly once.
    if (advance) begin
      ir_d  = instr;
      pc4_d = pc_plus4;
      vld_d = 1'b1;
      pc_d  = br_taken_D ? npc_in : pc_plus4;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_REQ;
      pc_q    <= RESET_PC;
      ir_q    <= NOP_INSTR;
      pc4_q   <= 32'd0;
      vld_q   <= 1'b0;
      buf_q   <= 32'd0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      pc4_q   <= pc4_d;
      vld_q   <= vld_d;
      buf_q   <= buf_d;
    end
  end

  assign imem.imem_req  = req & ~reset;
  assign imem.imem_addr = pc_q;
  assign PC_F           = pc_q;
  assign IR_D           = ir_q;
  assign PC4_D          = pc4_q;
  assign valid_D        = vld_q;

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed and randomized bench for fetch_ctrl, checked against a word-level
// model of the fetch stage (one pending fetched word, delivered when not stalled).
module tb_fetch_ctrl;

  localparam logic [31:0] RST_PC = 32'h0000_3000;

  logic        clk = 1'b0;
  logic        reset, stall, br;
  logic [31:0] npc;
  logic [31:0] pc_f, ir_d, pc4_d;
  logic        vld_d;

  always #5 clk = ~clk;

  fetch_ctrl_if mif();

  fetch_ctrl #(.RESET_PC(RST_PC), .NOP_INSTR(32'h0)) dut (
    .clk       (clk),
    .reset     (reset),
    .stall     (stall),
    .br_taken_D(br),
    .npc_in    (npc),
    .imem      (mif),
    .PC_F      (pc_f),
    .IR_D      (ir_d),
    .PC4_D     (pc4_d),
    .valid_D   (vld_d)
  );

  int n_checks = 0;
  int n_err    = 0;

  // Model: architectural registers plus "a word has arrived but not yet entered D".
  logic [31:0] m_pc, m_ir, m_pc4, m_word;
  logic        m_vld, m_have;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic r, input logic s, input logic b, input logic [31:0] n,
                       input logic a, input logic [31:0] d);
    reset          = r;
    stall          = s;
    br             = b;
    npc            = n;
    mif.imem_ack   = a;
    mif.imem_rdata = d;
  endtask

  task automatic model_step();
    logic [31:0] w;
    bit          avail;
    w     = 32'd0;
    avail = 1'b0;
    if (reset) begin
      m_pc   = RST_PC;
      m_ir   = 32'd0;
      m_pc4  = 32'd0;
      m_vld  = 1'b0;
      m_have = 1'b0;
      m_word = 32'd0;
    end else begin
      if (m_have) begin
        w     = m_word;
        avail = 1'b1;
      end else if (mif.imem_ack) begin
        w     = mif.imem_rdata;
        avail = 1'b1;
      end
      if (avail) begin
        if (!stall) begin
          m_ir   = w;
          m_pc4  = m_pc + 32'd4;
          m_vld  = 1'b1;
          m_pc   = br ? npc : m_pc + 32'd4;
          m_have = 1'b0;
        end else begin
          m_have = 1'b1;
          m_word = w;
        end
      end
    end
  endtask

  task automatic cycle();
    @(negedge clk);
    chk("imem_req",  {31'd0, mif.imem_req}, {31'd0, (!reset && !m_have)});
    chk("imem_addr", mif.imem_addr, m_pc);
    chk("PC_F",      pc_f, m_pc);
    chk("IR_D",      ir_d, m_ir);
    chk("PC4_D",     pc4_d, m_pc4);
    chk("valid_D",   {31'd0, vld_d}, {31'd0, m_vld});
    model_step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int lat;
    bit r, s, b, a, exp_req;
    drive(1'b1, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0);
    @(posedge clk);
    #1;
    m_pc = RST_PC; m_ir = 32'd0; m_pc4 = 32'd0; m_vld = 1'b0; m_have = 1'b0; m_word = 32'd0;

    // Reset with a stray ack: ignored, no request.
    drive(1'b1, 1'b0, 1'b0, 32'd0, 1'b1, 32'hDEADBEEF);
    cycle();
    chk("rst_ir", ir_d, 32'd0);
    chk("rst_pc", pc_f, 32'h3000);

    // Zero-wait stream.
    drive(1'b0, 1'b0, 1'b0, 32'd0, 1'b1, 32'h24010001); cycle();
    chk("seq_ir0", ir_d, 32'h24010001);
    chk("seq_pc4_0", pc4_d, 32'h3004);
    chk("seq_vld", {31'd0, vld_d}, 32'd1);
    drive(1'b0, 1'b0, 1'b0, 32'd0, 1'b1, 32'h24020002); cycle();
    chk("seq_pc4_1", pc4_d, 32'h3008);

    // Jump in D; delay slot at 0x3008 still enters D.
    drive(1'b0, 1'b0, 1'b1, 32'h3100, 1'b1, 32'h24030003); cycle();
    chk("j_ir", ir_d, 32'h24030003);
    chk("j_pc", pc_f, 32'h3100);
    drive(1'b0, 1'b0, 1'b0, 32'd0, 1'b1, 32'h24040004); cycle();
    chk("j_once", pc_f, 32'h3104);

    // Redirect to 0x3010, then a 3-cycle memory wait (stall mid-wait).
    drive(1'b0, 1'b0, 1'b1, 32'h3010, 1'b1, 32'h24050005); cycle();
    drive(1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0); cycle();
    drive(1'b0, 1'b1, 1'b0, 32'd0, 1'b0, 32'd0); cycle();
    drive(1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0); cycle();
    chk("wait_ir", ir_d, 32'h24050005);
    chk("wait_addr", mif.imem_addr, 32'h3010);
    drive(1'b0, 1'b0, 1'b0, 32'd0, 1'b1, 32'h24060006); cycle();
    chk("wait_done", pc4_d, 32'h3014);

    // Ack under a 2-cycle stall.
    drive(1'b0, 1'b1, 1'b0, 32'd0, 1'b1, 32'h8C220000); cycle();
    chk("hold_ir", ir_d, 32'h24060006);
    drive(1'b0, 1'b1, 1'b0, 32'd0, 1'b0, 32'd0); cycle();
    drive(1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0); cycle();
    chk("hold_rel_ir", ir_d, 32'h8C220000);
    chk("hold_rel_pc", pc_f, 32'h3018);

    // ack & stall & branch together; redirect taken at the advance.
    drive(1'b0, 1'b1, 1'b1, 32'h3200, 1'b1, 32'h11112222); cycle();
    chk("asb_pc", pc_f, 32'h3018);
    drive(1'b0, 1'b0, 1'b1, 32'h3200, 1'b0, 32'd0); cycle();
    chk("asb_ir", ir_d, 32'h11112222);
    chk("asb_pc2", pc_f, 32'h3200);

    // PC+4 wraps modulo 2^32.
    drive(1'b0, 1'b0, 1'b1, 32'hFFFFFFFC, 1'b1, 32'h2); cycle();
    drive(1'b0, 1'b0, 1'b0, 32'd0, 1'b1, 32'h3); cycle();
    chk("wrap_pc", pc_f, 32'h0);
    chk("wrap_pc4", pc4_d, 32'h0);

    // Reset while holding a parked word at 0x3040.
    drive(1'b0, 1'b0, 1'b1, 32'h3040, 1'b1, 32'h4); cycle();
    drive(1'b0, 1'b1, 1'b0, 32'd0, 1'b1, 32'h5); cycle();
    chk("hold_pc", pc_f, 32'h3040);
    drive(1'b1, 1'b1, 1'b0, 32'd0, 1'b0, 32'd0); cycle();
    chk("rh_pc", pc_f, 32'h3000);
    chk("rh_vld", {31'd0, vld_d}, 32'd0);
    chk("rh_ir", ir_d, 32'd0);
    drive(1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0); cycle();

    // Randomized traffic with variable memory latency.
    lat = 0;
    for (int i = 0; i < 400; i++) begin
      r = ($urandom_range(0, 99) < 2);
      s = ($urandom_range(0, 99) < 30);
      b = ($urandom_range(0, 99) < 20);
      exp_req = !r && !m_have;
      a = 1'b0;
      if (r) begin
        lat = 0;
      end else if (exp_req) begin
        if (lat == 0) begin
          a   = 1'b1;
          lat = $urandom_range(0, 3);
        end else begin
          lat--;
        end
      end
      drive(r, s, b, $urandom & 32'hFFFF_FFFC, a, $urandom);
      cycle();
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/fetch_ctrl.md
Name: fetch_ctrl

Overview:
- Fetch-stage sequencer for the 5-stage MIPS pipeline.
- Owns PC_F, drives a variable-latency instruction-memory req/ack handshake, and holds the IF/ID register (IR_D, PC4_D).
- Decides the next PC: sequential PC+4, or the D-stage next-PC target when a jump or taken branch sits in D (delay-slot semantics).
- Absorbs hazard-unit stalls with a one-entry skid buffer.

Parameters:
- RESET_PC, 32'h00003000, PC_F value after reset.
- NOP_INSTR, 32'h00000000, IR_D value after reset and while D holds no valid instruction.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  synchronous, active-high reset.
- stall  input  1  hazard-unit stall; freezes PC_F and the IF/ID register.
- br_taken_D  input  1  instruction in D is j/jal, or a taken beq/bne.
- npc_in  input  32  target computed in D from IR_D/PC4_D.
- imem_req  output  1  fetch request.
- imem_addr  output  32  fetch address (= PC_F).
- imem_ack  input  1  one-cycle pulse; imem_rdata valid in the same cycle.
- imem_rdata  input  32  fetched instruction.
- PC_F  output  32  current fetch PC.
- IR_D  output  32  instruction in D.
- PC4_D  output  32  PC+4 of the instruction in D.
- valid_D  output  1  IR_D holds a real fetched instruction.

Behaviour:
- Clock and reset: one clock (clk); reset is synchronous and active-high. All state updates on rising clk.
- Reset values:
  - PC_F = RESET_PC, IR_D = NOP_INSTR, PC4_D = 0, valid_D = 0, buf = 0.
  - State = S_REQ.
  - imem_req = 0 during any cycle in which reset is high.
  - An imem_ack arriving in a reset cycle is ignored.
- States:
  - S_REQ: imem_req = 1, imem_addr = PC_F.
  - S_HOLD: imem_req = 0; instruction parked in buf.
- advance: the single event that loads IR_D <= instr, PC4_D <= PC_F + 4, valid_D <= 1, and PC_F <= next_pc. It fires in exactly two cases:
  - S_REQ & imem_ack & !stall, with instr = imem_rdata.
  - S_HOLD & !stall, with instr = buf.
- next_pc = br_taken_D ? npc_in : PC_F + 4.
  - Sampled only in the advance cycle. IR_D changes only on advance, so each D-stage jump/branch redirects exactly once.
  - The instruction fetched while the branch is in D is the delay slot and always enters D.
- Transitions:
  - S_REQ, ack & !stall: advance, stay in S_REQ. The next request issues the following cycle at the new PC_F.
  - S_REQ, ack & stall: buf <= imem_rdata, go to S_HOLD; PC_F, IR_D and PC4_D are unchanged.
  - S_REQ, no ack: hold. imem_addr stays stable and imem_req stays high regardless of stall.
  - S_HOLD, stall: hold all registers.
  - S_HOLD, !stall: advance from buf, go to S_REQ.
- Throughput: one instruction per cycle with zero-wait memory (ack in the same cycle as req) and no stall.
- Latency:
  - Ack to IR_D visible: 1 cycle.
  - In S_HOLD, stall falling to IR_D update: 1 cycle.
- Arithmetic: PC + 4 is 32-bit modulo (0xFFFFFFFC + 4 = 0x00000000); no alignment check.
- Simultaneous events:
  - ack & stall & br_taken_D: buffer only. The redirect is taken later, at the advance, using the br_taken_D/npc_in present then.
  - reset with any other input: reset wins.
- Reset mid-fetch (including during S_HOLD): the outstanding request is abandoned, buf is discarded, and fetch restarts at RESET_PC. The memory shares reset and drops its pending ack.

Test Plan:
- Reset release, zero-wait memory returning 0x24010001, 0x24020002, 0x24030003, no stall -> imem_addr 0x3000, 0x3004, 0x3008 on consecutive cycles. IR_D follows one cycle behind each ack. PC4_D = 0x3004, 0x3008, 0x300C; valid_D rises one cycle after the first ack.
- j in D with br_taken_D=1, npc_in=0x00003100, delay slot at 0x3008 acked -> IR_D = delay-slot word, PC_F = 0x3100. The next imem_addr is 0x3100, and no second redirect occurs.
- Memory ack delayed 3 cycles at PC 0x3010 -> imem_req stays high and imem_addr stays 0x3010 for 4 cycles. IR_D/PC4_D are unchanged until the cycle after the ack.
- Ack with rdata 0x8C220000 and stall=1 held 2 cycles -> state S_HOLD, imem_req=0, IR_D unchanged. One cycle after stall drops, IR_D = 0x8C220000, PC_F += 4, and imem_req returns high.
- Ack & stall & br_taken_D (npc_in=0x3200) together, stall released next cycle with br_taken_D still 1 -> the buffered word enters D and PC_F = 0x3200.
- reset asserted while in S_HOLD with PC_F = 0x3040 -> next cycle: PC_F = 0x3000, valid_D = 0, IR_D = 0, imem_req = 0. After release, the first request is at 0x3000.
